// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment reader: segment bit positions,
// the active-low glyph table, FSM state encoding and decode result classes.
package seg7_pkg;

    // Bit position of each segment inside the 7-bit seg_n bus.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Active-low glyphs (a..g, 0 = segment lit).
    localparam logic [6:0] PAT_0     = 7'b0000001;
    localparam logic [6:0] PAT_1     = 7'b1001111;
    localparam logic [6:0] PAT_2     = 7'b0010010;
    localparam logic [6:0] PAT_3     = 7'b0000110;
    localparam logic [6:0] PAT_4     = 7'b1001100;
    localparam logic [6:0] PAT_5     = 7'b0100100;
    localparam logic [6:0] PAT_6     = 7'b0100000;
    localparam logic [6:0] PAT_7     = 7'b0001111;
    localparam logic [6:0] PAT_8     = 7'b0000000;
    localparam logic [6:0] PAT_9     = 7'b0000100;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        COMMITTED
    } state_t;

    typedef enum logic [1:0] {
        VALID,
        BLANK,
        INVALID
    } match_t;

endpackage

// File: rtl/seg7_pattern_match.sv
// Combinational reverse lookup: active-low segment pattern -> BCD value and
// a class telling whether it was a digit, an all-off blank or garbage.
module seg7_pattern_match
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] value,
    output match_t     result
);

    // Table lookup; value stays 0 for anything that is not a digit.
    always_comb begin
        value  = 4'd0;
        result = VALID;
        case (seg_n)
            PAT_0:     value = 4'd0;
            PAT_1:     value = 4'd1;
            PAT_2:     value = 4'd2;
            PAT_3:     value = 4'd3;
            PAT_4:     value = 4'd4;
            PAT_5:     value = 4'd5;
            PAT_6:     value = 4'd6;
            PAT_7:     value = 4'd7;
            PAT_8:     value = 4'd8;
            PAT_9:     value = 4'd9;
            PAT_BLANK: result = BLANK;
            default:   result = INVALID;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Reads back a multiplexed active-low 7-segment display. Each digit-select
// plus segment pattern must be seen unchanged for STABLE_CYCLES enabled
// samples before it is decoded and stored in that digit's slot.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_n,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    upd_pulse,
    output logic [2:0]              upd_index,
    output logic                    err_pulse
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

    logic [6:0]            seg_meta;
    logic [6:0]            s_seg;
    logic [NUM_DIGITS-1:0] dig_meta;
    logic [NUM_DIGITS-1:0] s_dig;

    state_t                state;
    logic [3:0]            cnt;
    logic [6:0]            ref_seg;
    logic [NUM_DIGITS-1:0] ref_dig;

    // Commit decided on the final stable sample, applied one clock later.
    logic                  pend;
    logic [2:0]            pend_idx;
    logic [3:0]            pend_val;
    match_t                pend_res;

    logic                  onehot;
    logic                  same;
    logic [2:0]            sample_idx;
    logic [3:0]            match_val;
    match_t                match_res;

    // Two-flop synchronisers; all-ones is the idle (nothing lit) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_meta <= '1;
            s_seg    <= '1;
            dig_meta <= '1;
            s_dig    <= '1;
        end else begin
            seg_meta <= seg_n;
            s_seg    <= seg_meta;
            dig_meta <= dig_n;
            s_dig    <= dig_meta;
        end
    end

    // Select qualification and position of the single active-low enable.
    always_comb begin
        onehot     = ($countones(~s_dig) == 1);
        same       = (s_seg == ref_seg) && (s_dig == ref_dig);
        sample_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!s_dig[i]) sample_idx = 3'(i);
        end
    end

    seg7_pattern_match u_match (
        .seg_n  (s_seg),
        .value  (match_val),
        .result (match_res)
    );

    // Settling FSM: counts identical enabled samples and requests a commit
    // exactly once per settled pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            ref_seg  <= '1;
            ref_dig  <= '1;
            pend     <= 1'b0;
            pend_idx <= 3'd0;
            pend_val <= 4'd0;
            pend_res <= VALID;
        end else begin
            pend <= 1'b0;
            if (sample_en) begin
                case (state)
                    IDLE: begin
                        if (onehot) begin
                            ref_seg <= s_seg;
                            ref_dig <= s_dig;
                            cnt     <= 4'd1;
                            state   <= SETTLING;
                        end
                    end
                    SETTLING: begin
                        if (!onehot) begin
                            cnt   <= 4'd0;
                            state <= IDLE;
                        end else if (!same) begin
                            ref_seg <= s_seg;
                            ref_dig <= s_dig;
                            cnt     <= 4'd1;
                        end else begin
                            cnt <= (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
                            if (cnt == CNT_MAX - 4'd1) begin
                                state    <= COMMITTED;
                                pend     <= 1'b1;
                                pend_idx <= sample_idx;
                                pend_val <= match_val;
                                pend_res <= match_res;
                            end
                        end
                    end
                    COMMITTED: begin
                        if (!onehot) begin
                            cnt   <= 4'd0;
                            state <= IDLE;
                        end else if (!same) begin
                            ref_seg <= s_seg;
                            ref_dig <= s_dig;
                            cnt     <= 4'd1;
                            state   <= SETTLING;
                        end
                    end
                    default: begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Registered commit: only the addressed digit's slot changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            digit_valid <= '0;
            blank       <= '0;
            upd_pulse   <= 1'b0;
            upd_index   <= 3'd0;
            err_pulse   <= 1'b0;
        end else begin
            upd_pulse <= pend;
            err_pulse <= pend && (pend_res == INVALID);
            if (pend) upd_index <= pend_idx;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (pend && (pend_idx == 3'(i))) begin
                    case (pend_res)
                        VALID: begin
                            digits[4*i +: 4] <= pend_val;
                            digit_valid[i]   <= 1'b1;
                            blank[i]         <= 1'b0;
                        end
                        BLANK: begin
                            digit_valid[i] <= 1'b0;
                            blank[i]       <= 1'b1;
                        end
                        default: begin
                            digit_valid[i] <= 1'b0;
                            blank[i]       <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: a run-length model of the settling
// rule is compared against the DUT on every falling edge, and directed
// scenarios add hand-computed expectations.
module tb_seg7_reader;

    localparam int ND  = 4;
    localparam int STB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_en = 1'b0;
    logic [6:0]    seg_n = 7'h7f;
    logic [ND-1:0] dig_n = '1;

    logic [4*ND-1:0] digits;
    logic [ND-1:0]   digit_valid;
    logic [ND-1:0]   blank;
    logic            upd_pulse;
    logic [2:0]      upd_index;
    logic            err_pulse;

    int checks = 0;
    int errors = 0;

    seg7_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(STB)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .digits      (digits),
        .digit_valid (digit_valid),
        .blank       (blank),
        .upd_pulse   (upd_pulse),
        .upd_index   (upd_index),
        .err_pulse   (err_pulse)
    );

    always #5 clk = ~clk;

    // Glyph table written out independently of the design package.
    logic [6:0] glyph [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

    // ---------------- behavioural model ----------------
    logic [6:0]      m_seg1 = '1, m_seg2 = '1, last_seg = '1, pend_seg = '1;
    logic [ND-1:0]   m_dig1 = '1, m_dig2 = '1, last_dig = '1;
    int              run = 0;
    bit              pend = 0;
    int              pend_idx = 0;
    logic [4*ND-1:0] exp_digits = '0;
    logic [ND-1:0]   exp_valid = '0, exp_blank = '0;
    logic            exp_upd = 0, exp_err = 0;
    logic [2:0]      exp_idx = '0;

    function automatic int zeros(input logic [ND-1:0] d);
        int n = 0;
        for (int i = 0; i < ND; i++) if (!d[i]) n++;
        return n;
    endfunction

    function automatic int low_pos(input logic [ND-1:0] d);
        int p = 0;
        for (int i = 0; i < ND; i++) if (!d[i]) p = i;
        return p;
    endfunction

    task automatic model_reset();
        m_seg1 = '1; m_seg2 = '1; m_dig1 = '1; m_dig2 = '1;
        run = 0; pend = 0;
        exp_digits = '0; exp_valid = '0; exp_blank = '0;
        exp_upd = 0; exp_err = 0; exp_idx = '0;
    endtask

    task automatic model_step();
        int v;
        // apply a commit decided on the previous edge
        exp_upd = 0; exp_err = 0;
        if (pend) begin
            v = -1;
            for (int i = 0; i < 10; i++) if (glyph[i] == pend_seg) v = i;
            exp_upd = 1;
            exp_idx = 3'(pend_idx);
            if (v >= 0) begin
                exp_digits[4*pend_idx +: 4] = 4'(v);
                exp_valid[pend_idx] = 1; exp_blank[pend_idx] = 0;
            end else if (pend_seg == 7'h7f) begin
                exp_valid[pend_idx] = 0; exp_blank[pend_idx] = 1;
            end else begin
                exp_valid[pend_idx] = 0; exp_blank[pend_idx] = 0; exp_err = 1;
            end
        end
        pend = 0;
        // run length of identical, properly selected, enabled samples
        if (sample_en) begin
            if (zeros(m_dig2) != 1) run = 0;
            else if (run > 0 && m_seg2 == last_seg && m_dig2 == last_dig) begin
                if (run < STB) begin
                    run++;
                    if (run == STB) begin
                        pend = 1; pend_seg = last_seg; pend_idx = low_pos(last_dig);
                    end
                end
            end else begin
                last_seg = m_seg2; last_dig = m_dig2; run = 1;
            end
        end
        m_seg2 = m_seg1; m_dig2 = m_dig1;
        m_seg1 = seg_n;  m_dig1 = dig_n;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("digits",      32'(digits),      32'(exp_digits));
        check("digit_valid", 32'(digit_valid), 32'(exp_valid));
        check("blank",       32'(blank),       32'(exp_blank));
        check("upd_pulse",   32'(upd_pulse),   32'(exp_upd));
        check("upd_index",   32'(upd_index),   32'(exp_idx));
        check("err_pulse",   32'(err_pulse),   32'(exp_err));
    end

    // ---------------- directed stimulus ----------------
    int win_upd = 0, win_err = 0, win_cyc = 0, first_upd = 0;

    task automatic win_clear();
        win_upd = 0; win_err = 0; win_cyc = 0; first_upd = 0;
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            win_cyc++;
            if (upd_pulse) begin
                win_upd++;
                if (first_upd == 0) first_upd = win_cyc;
            end
            if (err_pulse) win_err++;
        end
    endtask

    task automatic drive(input logic [ND-1:0] d, input logic [6:0] s);
        dig_n = d; seg_n = s;
    endtask

    logic [6:0] scan_pat [4];

    initial begin
        scan_pat = '{7'b1001111, 7'b0000100, 7'b0000001, 7'b0001111};

        // Reset with random inputs: everything stays at zero
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            seg_n = 7'($urandom); dig_n = ND'($urandom); sample_en = 1'($urandom);
            hold(1);
            check("rst_digits", 32'(digits), 32'h0);
            check("rst_pulse",  32'({upd_pulse, err_pulse}), 32'h0);
        end
        drive(4'b1111, 7'h7f); sample_en = 1; rst = 0;
        win_clear(); hold(5);
        check("post_rst_nopulse", 32'(win_upd), 32'd0);

        // Basic commit of "2" on digit 0
        win_clear(); drive(4'b1110, 7'b0010010); hold(10);
        check("basic_latency", 32'(first_upd), 32'd6);
        check("basic_count",   32'(win_upd),   32'd1);
        check("basic_digit",   32'(digits[3:0]), 32'd2);
        check("basic_valid",   32'(digit_valid), 32'b0001);
        check("basic_index",   32'(upd_index),   32'd0);

        // Glitching between "3" and "8" on digit 1, then settle on "8"
        win_clear();
        for (int i = 0; i < 6; i++) begin
            drive(4'b1101, (i % 2) ? 7'b0000000 : 7'b0000110); hold(2);
        end
        check("glitch_nopulse", 32'(win_upd), 32'd0);
        win_clear(); drive(4'b1101, 7'b0000000); hold(8);
        check("glitch_count", 32'(win_upd), 32'd1);
        check("glitch_digit", 32'(digits[7:4]), 32'd8);
        check("glitch_index", 32'(upd_index), 32'd1);

        // Two multiplex scans of 1,9,0,7
        win_clear();
        for (int s = 0; s < 2; s++)
            for (int d = 0; d < 4; d++) begin
                drive(~(4'b0001 << d), scan_pat[d]); hold(5);
            end
        hold(3);
        check("scan_count",  32'(win_upd), 32'd8);
        check("scan_digits", 32'(digits), 32'h7091);
        check("scan_valid",  32'(digit_valid), 32'hf);

        // Digit 2: "6", then an unknown glyph, then blank
        drive(4'b1011, 7'b0100000); hold(8);
        check("d2_six", 32'(digits[11:8]), 32'd6);
        win_clear(); drive(4'b1011, 7'b1111110); hold(8);
        check("inv_err",    32'(win_err), 32'd1);
        check("inv_upd",    32'(win_upd), 32'd1);
        check("inv_valid",  32'(digit_valid[2]), 32'd0);
        check("inv_digit",  32'(digits[11:8]), 32'd6);
        win_clear(); drive(4'b1011, 7'b1111111); hold(8);
        check("blank_err",   32'(win_err), 32'd0);
        check("blank_flag",  32'(blank[2]), 32'd1);
        check("blank_digit", 32'(digits[11:8]), 32'd6);

        // Two digits selected at once: never commits
        win_clear(); drive(4'b1100, 7'b0100100); hold(8);
        check("multi_sel_nopulse", 32'(win_upd), 32'd0);

        // Reset while "4" is settling, then a full settle is needed
        win_clear(); drive(4'b1110, 7'b1001100); hold(3);
        rst = 1; hold(1); rst = 0;
        check("rst_mid_nopulse", 32'(win_upd), 32'd0);
        win_clear(); hold(10);
        check("rst_mid_latency", 32'(first_upd), 32'd6);
        check("rst_mid_digit",   32'(digits[3:0]), 32'd4);

        // Sample enable gating: "3" on digit 3 with enable on every other cycle
        win_clear(); drive(4'b0111, 7'b0000110);
        for (int i = 0; i < 14; i++) begin
            sample_en = 1'(i % 2); hold(1);
        end
        sample_en = 1; hold(2);
        check("en_count", 32'(win_upd), 32'd1);
        check("en_digit", 32'(digits[15:12]), 32'd3);

        // Mixed random holds checked by the model
        for (int i = 0; i < 30; i++) begin
            drive(($urandom_range(0, 4) == 0) ? 4'(~$urandom_range(0, 15))
                                              : ~(4'b0001 << $urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 9)]);
            sample_en = ($urandom_range(0, 3) != 0);
            hold($urandom_range(1, 7));
        end
        sample_en = 1; hold(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Receive-side counterpart of the team's 4-bit to 7-segment decoder.
- Samples a multiplexed, active-low 7-segment display bus (segments plus per-digit enables) from an external or captured display.
- Waits until each pattern has settled, then converts it back to a BCD digit and stores one value per digit position.
- Used in self-check and loopback paths to confirm the displayed value.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 3, consecutive identical samples required before commit (2..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sample_en  input  1  sample strobe. Only cycles with sample_en=1 advance the settling logic.
- seg_n  input  7  active-low segments; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- dig_n  input  NUM_DIGITS  active-low digit enables; exactly one low = valid digit select.
- digits  output  4*NUM_DIGITS  stored BCD values; digit k occupies bits [4k+3:4k].
- digit_valid  output  NUM_DIGITS  per digit: last commit decoded to 0-9.
- blank  output  NUM_DIGITS  per digit: last commit was all segments off.
- upd_pulse  output  1  one-cycle pulse on every commit.
- upd_index  output  3  digit index of the latest commit; holds between commits.
- err_pulse  output  1  one-cycle pulse when a commit pattern is unrecognised.

Behaviour:
- Reset (async, rst=1): all outputs 0; synchronisers at all-ones (inactive); state IDLE; counter 0.
- Input path: seg_n and dig_n each pass through a 2-flop synchroniser. All logic below uses the synchronised values s_seg and s_dig.
- Pattern table, active-low value on seg_n (a..g):
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 4 = 1001100
  - 5 = 0100100
  - 6 = 0100000
  - 7 = 0001111
  - 8 = 0000000
  - 9 = 0000100
  - blank = 1111111
  - Any other value is invalid.
- onehot: true when exactly one bit of s_dig is 0.
- State machine (transitions evaluated only on sample_en=1):
  - IDLE: if onehot, latch {s_dig, s_seg} as ref, set cnt=1, go to SETTLING. Otherwise stay.
  - SETTLING:
    - Not onehot: go to IDLE, cnt=0.
    - Sample differs from ref but is onehot: reload ref, cnt=1, stay.
    - Sample equals ref: cnt++. When cnt reaches STABLE_CYCLES, commit and go to COMMITTED.
  - COMMITTED:
    - Sample equals ref: stay; no further commits.
    - Sample differs and is onehot: reload ref, cnt=1, go to SETTLING.
    - Not onehot: go to IDLE.
- Commit, registered (outputs update in the cycle after the final stable sample); k = index of the low bit in ref dig:
  - Pattern 0-9: digits[k]=value, digit_valid[k]=1, blank[k]=0.
  - Blank: digits[k] holds, digit_valid[k]=0, blank[k]=1.
  - Invalid: digits[k] holds, digit_valid[k]=0, blank[k]=0, err_pulse=1.
  - Every commit: upd_pulse=1, upd_index=k.
- Latency from a pin change to commit outputs, with sample_en tied high: 2 + STABLE_CYCLES + 1 clocks.
- Other digits' registers are never altered by a commit.
- sample_en=0: state, counter and ref all hold; no pulses.
- Counter saturates at STABLE_CYCLES; no wrap.
- A change of seg_n alone while dig_n is held counts as a new pattern (restart settling).
- Reset mid-SETTLING: immediately IDLE. No pulse fires, even if the pattern stays stable when reset drops; a full settle is required again.

Decomposition:
- Shared package seg7_pkg:
  - segment bit-index constants SEG_A..SEG_G;
  - the ten pattern constants and PAT_BLANK;
  - state encoding (IDLE, SETTLING, COMMITTED);
  - decode-result enum (VALID, BLANK, INVALID).
- One sub-module, seg7_pattern_match: combinational, 7-bit active-low pattern in; 4-bit value and 2-bit result class out.
- The FSM, counter and per-digit registers live in seg7_reader.

Test Plan:
- Reset: rst=1 with random inputs → all outputs 0; release rst with dig_n all ones → no pulses.
- Basic commit: sample_en=1, dig_n=1110, seg_n=0010010 held 10 cycles → single upd_pulse after 6 clocks; digits[3:0]=2; digit_valid=0001; upd_index=0.
- Glitch rejection (STABLE_CYCLES=3): seg_n toggles between "3" and "8" every 2 cycles → no upd_pulse. Then hold "8" → commit with digits[k]=8.
- Multiplex scan: 4 digits cycling 1,9,0,7 (dig_n 1110,1101,1011,0111), 5 samples each → digits=0x7091, digit_valid=1111, four upd_pulses per scan, no repeats while a digit is held.
- Invalid/blank: digit 2 shows 1111110 → err_pulse, digit_valid[2]=0, digits[11:8] unchanged. Then 1111111 → blank[2]=1, no err_pulse.
- Not-onehot and reset: dig_n=1100 with a stable "5" → no commit. Assert rst during SETTLING of "4" → no commit; after release, a full settle is needed before upd_pulse.
